// File: rtl/decoder_pkg.sv
// Shared types, mode encodings and the one-hot helper for the scan decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // One-hot decode of sel into a 64-bit vector; indices outside 2**n give all zeros.
    function automatic logic [63:0] onehot(input logic [5:0] sel, input int n);
        logic [63:0] r;
        r = 64'd0;
        if (int'(sel) < (1 << n)) begin
            r[sel] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for SCAN mode: counts 0..DWELL-1 while run is high and
// pulses tick on the last count. clr makes the current cycle count as 0,
// so a freshly entered scan always dwells a full DWELL cycles.
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt;

    assign w_cnt = clr ? '0 : r_cnt;
    assign tick  = run & (w_cnt == LAST);

    // Advance the count only while scanning; otherwise hold it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= tick ? '0 : w_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// N-to-2**N decoder with a direct-load select and an auto-incrementing scan
// mode. Outputs are registered and computed from next-state values, so an
// accepted d_in shows on d_out one cycle after the accepting edge.
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int N          = 4,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      d_in,
    input  logic              d_valid,
    output logic              d_ready,
    output logic [2**N-1:0]   d_out,
    output logic [N-1:0]      sel_out,
    output logic              wrap
);

    localparam int OUT_W = 2**N;
    localparam logic [OUT_W-1:0] POLARITY = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    state_t           r_state;
    state_t           w_state_next;
    logic [N-1:0]     r_sel;
    logic [N-1:0]     w_sel_next;
    logic             r_wrap;
    logic             w_wrap_next;
    logic [OUT_W-1:0] r_dout;
    logic [OUT_W-1:0] w_dout_next;
    logic             w_ready;
    logic             w_accept;
    logic             w_run;
    logic             w_clr;
    logic             w_tick;

    // d_ready is forced low in reset so nothing is accepted on a reset edge.
    assign w_ready  = rst_n & en & (mode == MODE_DIRECT);
    assign w_accept = d_valid & w_ready;
    assign w_run    = (w_state_next == SCAN);
    assign w_clr    = (r_state != SCAN);

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // Next state follows en/mode every cycle.
    always_comb begin
        w_state_next = BLANK;
        if (en) begin
            w_state_next = (mode == MODE_SCAN) ? SCAN : DIRECT;
        end
    end

    // Next select, wrap pulse and decoded output.
    always_comb begin
        w_sel_next  = r_sel;
        w_wrap_next = 1'b0;
        if (w_accept) begin
            w_sel_next = d_in;
        end else if (w_tick) begin
            w_sel_next  = r_sel + 1'b1;
            w_wrap_next = (r_sel == {N{1'b1}});
        end
        if (w_state_next == BLANK) begin
            w_dout_next = POLARITY;
        end else begin
            w_dout_next = OUT_W'(onehot(6'(w_sel_next), N)) ^ POLARITY;
        end
    end

    // State and output registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BLANK;
            r_sel   <= '0;
            r_wrap  <= 1'b0;
            r_dout  <= POLARITY;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_wrap  <= w_wrap_next;
            r_dout  <= w_dout_next;
        end
    end

    assign d_ready = w_ready;
    assign d_out   = r_dout;
    assign sel_out = r_sel;
    assign wrap    = r_wrap;

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter N, default 4, select width; output width is 2**N; legal range 1..6.
REQ-002 Parameter DWELL, default 4, clock cycles per scan step; legal range 1..65535.
REQ-003 Parameter ACTIVE_LOW, default 0; when 1, every bit of d_out SHALL be inverted (one-cold output).
REQ-004 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 en  input  1  1 = drive outputs; 0 = blank all outputs.
REQ-007 mode  input  1  0 = DIRECT (select taken from d_in); 1 = SCAN (select auto-increments).
REQ-008 d_in  input  N  select value; meaningful only when d_valid=1.
REQ-009 d_valid  input  1  d_in is offered this cycle.
REQ-010 d_ready  output  1  block accepts d_in this cycle.
REQ-011 d_out  output  2**N  registered one-hot (or one-cold) decode of sel_out.
REQ-012 sel_out  output  N  registered current select index.
REQ-013 wrap  output  1  one-cycle pulse when a SCAN step moves sel from 2**N-1 to 0.

Function
REQ-014 FSM states SHALL be BLANK, DIRECT and SCAN; the state SHALL be re-evaluated every cycle: en=0 -> BLANK; en=1 and mode=0 -> DIRECT; en=1 and mode=1 -> SCAN.
REQ-015 d_ready SHALL be combinational and equal to (en & ~mode); it SHALL be 0 during reset.
REQ-016 An accept SHALL occur when d_valid & d_ready are both 1 at a rising edge; at that edge sel SHALL load d_in.
REQ-017 d_out SHALL be driven from the next-state value, so it reflects a newly accepted d_in in the first cycle after the accepting edge (latency 1).
REQ-018 In BLANK, all bits of d_out SHALL be inactive (0, or 1 if ACTIVE_LOW=1), and sel, the dwell counter and wrap SHALL hold their values (wrap held at 0).
REQ-019 In DIRECT with no accept, sel SHALL hold; d_valid=1 while d_ready=0 SHALL be ignored, and no data SHALL be queued.
REQ-020 In SCAN, a dwell counter SHALL count 0..DWELL-1; when it reaches DWELL-1, sel SHALL increment modulo 2**N and the counter SHALL return to 0.
REQ-021 With DWELL=1, sel SHALL advance every cycle.
REQ-022 wrap SHALL be 1 for exactly the cycle after the edge on which sel goes from 2**N-1 to 0, and 0 at all other times.
REQ-023 On entering SCAN from DIRECT or BLANK, the scan SHALL start from the current sel, with the dwell counter cleared to 0.
REQ-024 On leaving SCAN for DIRECT, sel SHALL hold its current value until the next accept.
REQ-025 Exactly one bit of d_out SHALL be active outside BLANK; d_out SHALL never show X.
REQ-026 If en falls on the same edge as an offered d_in, no accept SHALL occur, because d_ready is already 0.

Reset
REQ-027 While rst_n=0 at a rising edge, the state SHALL become BLANK, sel SHALL become 0, the dwell counter SHALL become 0 and wrap SHALL become 0.
REQ-028 During reset, d_out SHALL be all inactive.
REQ-029 Reset asserted in the middle of a scan or an accept SHALL override every other input on that edge.
REQ-030 In the first cycle after reset release with en=1 and mode=0, d_out SHALL show index 0, and no spurious wrap SHALL occur.

Structure
REQ-031 A shared package decoder_pkg SHALL hold the state enum (BLANK, DIRECT, SCAN), the mode constants, and a one-hot function onehot(sel, N).
REQ-032 The dwell counter SHALL be a separate sub-module named dwell_timer, with ports clk, rst_n, run, clr and tick.
REQ-033 The total RTL SHALL be between 120 and 400 lines.

Verification (N=4, DWELL=3, ACTIVE_LOW=0 unless stated)
REQ-034 Reset, then en=1, mode=0, d_in=4'hA, d_valid=1 for 1 cycle -> one cycle later d_out=16'h0400 and sel_out=4'hA; d_out stays there with d_valid=0.
REQ-035 mode=1 from sel=4'hE -> sel_out steps E,F,0,1 every 3 cycles; wrap=1 for exactly one cycle at the F->0 step.
REQ-036 en=0 mid-scan at sel=5 for 10 cycles -> d_out=16'h0000 and sel_out=5 held; en=1 -> scan resumes at 5 with a full 3-cycle dwell.
REQ-037 mode=1 with d_valid=1, d_in=4'h3 -> d_ready=0 and sel is unaffected by d_in.
REQ-038 rst_n=0 for one cycle while scanning at sel=4'hF -> sel_out=0, d_out=16'h0000, wrap=0; with en=1 and mode=0 after release -> d_out=16'h0001.
REQ-039 With ACTIVE_LOW=1, N=3 and d_in=3'd2 accepted -> d_out=8'hFB; with en=0 -> d_out=8'hFF.
